johnson_seq_decoder: RTL

Receive-side checker and decoder for the 3-bit, six-state Johnson code sequence 000→001→011→111→110→100→000. It samples the code word from a Johnson-counter source and converts each legal word to a step index 0–5. It verifies that successive samples follow the sequence, acquires and loses lock, and counts completed laps. It sits downstream of any Johnson-counter source, as its monitor and consumer.

---
 rtl/johnson_seq_decoder.sv | 135 +++++++++++++
 1 files changed

// File: rtl/johnson_seq_decoder.sv
// rtl/johnson_seq_decoder.sv - Johnson 3-bit sequence decoder, lock tracker and lap counter
// Optional macro JDEC_HOLD_EN: a repeated legal code is a stall instead of a sequence error.
module johnson_seq_decoder #(
    parameter int LAP_W    = 8,
    parameter int LOCK_CNT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       code_in,
    input  logic             code_valid,
    output logic [2:0]       step,
    output logic             step_valid,
    output logic             locked,
    output logic             seq_err,
    output logic             lap_tick,
    output logic [LAP_W-1:0] lap_count
);
    localparam int MW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
    localparam logic [MW-1:0] LOCK_MAX = MW'(LOCK_CNT);

    typedef enum logic [1:0] {UNLOCKED, LOCKING, LOCKED} state_t;

    state_t           state_q, state_d;
    logic [MW-1:0]    match_q, match_d, match_inc;
    logic [2:0]       ref_q, ref_d, step_d, dec, exp_next;
    logic             legal, is_next, hold;
    logic             sv_d, err_d, lap_d;
    logic [LAP_W-1:0] lap_cnt_d;

    always_comb begin
        legal = 1'b1;
        dec   = 3'd0;
        case (code_in)
            3'b000:  dec = 3'd0;
            3'b001:  dec = 3'd1;
            3'b011:  dec = 3'd2;
            3'b111:  dec = 3'd3;
            3'b110:  dec = 3'd4;
            3'b100:  dec = 3'd5;
            default: legal = 1'b0;
        endcase
    end

    assign exp_next  = (ref_q == 3'd5) ? 3'd0 : ref_q + 3'd1;
    assign is_next   = legal && (dec == exp_next);
    assign match_inc = match_q + 1'b1;

`ifdef JDEC_HOLD_EN
    assign hold = legal && (dec == ref_q);
`else
    assign hold = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        match_d   = match_q;
        ref_d     = ref_q;
        step_d    = step;
        sv_d      = 1'b0;
        err_d     = 1'b0;
        lap_d     = 1'b0;
        lap_cnt_d = lap_count;
        if (code_valid) begin
            if (legal) begin
                step_d = dec;
                sv_d   = 1'b1;
                ref_d  = dec;
            end
            case (state_q)
                UNLOCKED: begin
                    if (legal) begin
                        state_d = LOCKING;
                        match_d = '0;
                    end
                end
                LOCKING: begin
                    if (!legal) begin
                        state_d = UNLOCKED;
                    end else if (hold) begin
                        match_d = match_q;
                    end else if (is_next) begin
                        match_d = match_inc;
                        if (match_inc == LOCK_MAX)
                            state_d = LOCKED;
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    if (!legal) begin
                        err_d   = 1'b1;
                        state_d = UNLOCKED;
                    end else if (hold) begin
                        state_d = LOCKED;
                    end else if (is_next) begin
                        // a 5 -> 0 step closes one lap
                        if (ref_q == 3'd5) begin
                            lap_d     = 1'b1;
                            lap_cnt_d = lap_count + 1'b1;
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = LOCKING;
                        match_d = '0;
                    end
                end
                default: state_d = UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= UNLOCKED;
            match_q    <= '0;
            ref_q      <= 3'd0;
            step       <= 3'd0;
            step_valid <= 1'b0;
            locked     <= 1'b0;
            seq_err    <= 1'b0;
            lap_tick   <= 1'b0;
            lap_count  <= '0;
        end else begin
            state_q    <= state_d;
            match_q    <= match_d;
            ref_q      <= ref_d;
            step       <= step_d;
            step_valid <= sv_d;
            locked     <= (state_d == LOCKED);
            seq_err    <= err_d;
            lap_tick   <= lap_d;
            lap_count  <= lap_cnt_d;
        end
    end
endmodule
